// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the iterative divider: state encoding and constants.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

    localparam int DIV_WIDTH = 32;

    // Quotient reported for a zero divisor.
    localparam logic [DIV_WIDTH-1:0] DIV_ZERO_Q = {DIV_WIDTH{1'b1}};

endpackage

// File: rtl/div_iter_if.sv
// EXE-stage divider handshake: operands and control from the pipeline, stall and HI/LO results back.
interface div_iter_if #(
    parameter int WIDTH = 32
);

    logic             div_start;
    logic             div_signed;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             flush;
    logic             stage_advance;
    logic             div_busy;
    logic             res_valid;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

    modport master (
        output div_start, div_signed, src_a, src_b, flush, stage_advance,
        input  div_busy, res_valid, quotient, remainder
    );

    modport slave (
        input  div_start, div_signed, src_a, src_b, flush, stage_advance,
        output div_busy, res_valid, quotient, remainder
    );

endinterface

// File: rtl/div_step.sv
// One combinational restoring-division iteration on the {remainder, quotient} shift pair.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0] rem_sh_s;
    logic [WIDTH:0] trial_s;

    // Partial remainder stays below the divisor, so one extra bit is enough to see the sign.
    assign rem_sh_s = {rem, quo[WIDTH-1]};
    assign trial_s  = rem_sh_s - {1'b0, divisor};

    // Keep the trial difference when it did not borrow, else restore.
    always_comb begin
        rem_next = rem_sh_s[WIDTH-1:0];
        quo_next = {quo[WIDTH-2:0], 1'b0};
        if (trial_s[WIDTH] == 1'b0) begin
            rem_next = trial_s[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_next = rem_sh_s[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider for DIV/DIVU in EXE; results in WIDTH+1 cycles.
// Optional macro DIV_EARLY_ZERO_EN: a zero divisor skips iteration and goes straight to DONE.
module div_iter
    import cpu_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic       clk,
    input  logic       resetn,
    div_iter_if.slave  bus
);

    localparam int                 CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
    localparam logic [WIDTH-1:0]   ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0]   ZERO_Q   = {WIDTH{1'b1}};

    div_state_e       state_r;
    div_state_e       state_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] dvsr_r;
    logic [WIDTH-1:0] a_orig_r;
    logic             q_neg_r;
    logic             r_neg_r;
    logic             b_zero_r;
    logic [WIDTH-1:0] quo_out_r;
    logic [WIDTH-1:0] rem_out_r;
    logic             res_valid_r;

    logic             accept_s;
    logic             iter_s;
    logic             last_s;
    logic             busy_s;
    logic             early_zero_s;
    logic             b_is_zero_s;
    logic [WIDTH-1:0] abs_a_s;
    logic [WIDTH-1:0] abs_b_s;
    logic [WIDTH-1:0] rem_step_s;
    logic [WIDTH-1:0] quo_step_s;

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
        return ~x + ONE;
    endfunction

    assign b_is_zero_s = (bus.src_b == {WIDTH{1'b0}});
    assign abs_a_s     = (bus.div_signed & bus.src_a[WIDTH-1]) ? negate(bus.src_a) : bus.src_a;
    assign abs_b_s     = (bus.div_signed & bus.src_b[WIDTH-1]) ? negate(bus.src_b) : bus.src_b;

`ifdef DIV_EARLY_ZERO_EN
    assign early_zero_s = accept_s & b_is_zero_s;
`else
    assign early_zero_s = 1'b0;
`endif

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_r),
        .quo      (quo_r),
        .divisor  (dvsr_r),
        .rem_next (rem_step_s),
        .quo_next (quo_step_s)
    );

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; flush and a squashed instruction both abandon the operation.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.flush) begin
                    state_next_s = IDLE;
                end else if (bus.div_start) begin
                    state_next_s = early_zero_s ? DONE : CALC;
                end else begin
                    state_next_s = IDLE;
                end
            end
            CALC: begin
                if (bus.flush || !bus.div_start) begin
                    state_next_s = IDLE;
                end else if (cnt_r == CNT_LAST) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = CALC;
                end
            end
            DONE: begin
                if (bus.flush || bus.stage_advance) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Control strobes and the combinational stall request.
    always_comb begin
        accept_s = 1'b0;
        iter_s   = 1'b0;
        last_s   = 1'b0;
        busy_s   = bus.div_start & ~bus.flush & (state_r != DONE);
        case (state_r)
            IDLE: begin
                accept_s = bus.div_start & ~bus.flush;
            end
            CALC: begin
                iter_s = bus.div_start & ~bus.flush;
                last_s = bus.div_start & ~bus.flush & (cnt_r == CNT_LAST);
            end
            DONE: begin
                accept_s = 1'b0;
            end
            default: begin
                accept_s = 1'b0;
            end
        endcase
    end

    // Operand capture and the per-cycle restoring iteration.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_r    <= {CNT_W{1'b0}};
            rem_r    <= {WIDTH{1'b0}};
            quo_r    <= {WIDTH{1'b0}};
            dvsr_r   <= {WIDTH{1'b0}};
            a_orig_r <= {WIDTH{1'b0}};
            q_neg_r  <= 1'b0;
            r_neg_r  <= 1'b0;
            b_zero_r <= 1'b0;
        end else if (accept_s) begin
            cnt_r    <= {CNT_W{1'b0}};
            rem_r    <= {WIDTH{1'b0}};
            quo_r    <= abs_a_s;
            dvsr_r   <= abs_b_s;
            a_orig_r <= bus.src_a;
            q_neg_r  <= bus.div_signed & (bus.src_a[WIDTH-1] ^ bus.src_b[WIDTH-1]);
            r_neg_r  <= bus.div_signed & bus.src_a[WIDTH-1];
            b_zero_r <= b_is_zero_s;
        end else if (iter_s) begin
            cnt_r <= cnt_r + CNT_ONE;
            rem_r <= rem_step_s;
            quo_r <= quo_step_s;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Result registers: sign fixups, or the forced divide-by-zero result, are applied on entry to DONE.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            quo_out_r   <= {WIDTH{1'b0}};
            rem_out_r   <= {WIDTH{1'b0}};
            res_valid_r <= 1'b0;
        end else begin
            res_valid_r <= (state_next_s == DONE);
            if (early_zero_s) begin
                quo_out_r <= ZERO_Q;
                rem_out_r <= bus.src_a;
            end else if (last_s && b_zero_r) begin
                quo_out_r <= ZERO_Q;
                rem_out_r <= a_orig_r;
            end else if (last_s) begin
                quo_out_r <= q_neg_r ? negate(quo_step_s) : quo_step_s;
                rem_out_r <= r_neg_r ? negate(rem_step_s) : rem_step_s;
            end else begin
                quo_out_r <= quo_out_r;
                rem_out_r <= rem_out_r;
            end
        end
    end

    assign bus.div_busy  = busy_s;
    assign bus.res_valid = res_valid_r;
    assign bus.quotient  = quo_out_r;
    assign bus.remainder = rem_out_r;

endmodule

// File: tb/tb_div_iter.sv
// Directed testbench for div_iter with an arithmetic reference model checked every cycle.
module tb_div_iter;

    localparam int W = 32;
`ifdef DIV_EARLY_ZERO_EN
    localparam bit EARLY = 1'b1;
    localparam int ZLAT  = 1;
`else
    localparam bit EARLY = 1'b0;
    localparam int ZLAT  = W + 1;
`endif

    logic clk;
    logic resetn;
    int   checks = 0;
    int   errors = 0;

    div_iter_if #(.WIDTH(W)) bus ();

    div_iter #(.WIDTH(W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference: plain integer division, truncating toward zero; {quotient, remainder}.
    function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {q, r};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model of the observable timing: busy until results appear WIDTH+1 cycles after accept.
    logic        m_pend;
    logic        m_done;
    int          m_age;
    logic [63:0] m_qr;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_pend <= 1'b0;
            m_done <= 1'b0;
            m_age  <= 0;
        end else if (bus.flush) begin
            m_pend <= 1'b0;
            m_done <= 1'b0;
        end else if (m_done) begin
            if (bus.stage_advance) m_done <= 1'b0;
        end else if (m_pend) begin
            if (!bus.div_start) begin
                m_pend <= 1'b0;
            end else if (m_age + 1 == W + 1) begin
                m_pend <= 1'b0;
                m_done <= 1'b1;
            end else begin
                m_age <= m_age + 1;
            end
        end else if (bus.div_start) begin
            m_qr <= ref_div(bus.div_signed, bus.src_a, bus.src_b);
            if (EARLY && bus.src_b == 32'd0) begin
                m_done <= 1'b1;
            end else begin
                m_pend <= 1'b1;
                m_age  <= 1;
            end
        end
    end

    always @(negedge clk) begin
        if (resetn) begin
            chk("busy", 64'(bus.div_busy), 64'(bus.div_start & ~bus.flush & ~m_done));
            chk("res_valid", 64'(bus.res_valid), 64'(m_done));
            if (m_done) begin
                chk("quotient", 64'(bus.quotient), 64'(m_qr[63:32]));
                chk("remainder", 64'(bus.remainder), 64'(m_qr[31:0]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eq, input logic [31:0] er, input int lat, input int hold);
        int n;
        logic [31:0] q0;
        logic [31:0] r0;
        bus.div_signed = sgn;
        bus.src_a      = a;
        bus.src_b      = b;
        bus.div_start  = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
            bus.src_a      = $urandom;
            bus.src_b      = $urandom;
            bus.div_signed = ~sgn;
        end while (!bus.res_valid && n < 100);
        chk("latency", 64'(n), 64'(lat));
        chk("lit_quotient", 64'(bus.quotient), 64'(eq));
        chk("lit_remainder", 64'(bus.remainder), 64'(er));
        q0 = bus.quotient;
        r0 = bus.remainder;
        repeat (hold) tick();
        if (hold > 0) begin
            chk("hold_quotient", 64'(bus.quotient), 64'(q0));
            chk("hold_remainder", 64'(bus.remainder), 64'(r0));
            chk("hold_valid", 64'(bus.res_valid), 64'd1);
        end
        bus.stage_advance = 1'b1;
        tick();
        bus.stage_advance = 1'b0;
        bus.div_start     = 1'b0;
    endtask

    initial begin
        resetn            = 1'b0;
        bus.div_start     = 1'b0;
        bus.div_signed    = 1'b0;
        bus.src_a         = 32'd0;
        bus.src_b         = 32'd0;
        bus.flush         = 1'b0;
        bus.stage_advance = 1'b0;

        chk("pin_div_neg", ref_div(1'b1, 32'hFFFF_FFF9, 32'd2), {32'hFFFF_FFFD, 32'hFFFF_FFFF});
        chk("pin_div_ovf", ref_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF), {32'h8000_0000, 32'd0});
        chk("pin_divu_zero", ref_div(1'b0, 32'd5, 32'd0), {32'hFFFF_FFFF, 32'd5});

        repeat (3) tick();
        chk("reset_valid", 64'(bus.res_valid), 64'd0);
        chk("reset_quotient", 64'(bus.quotient), 64'd0);
        chk("reset_remainder", 64'(bus.remainder), 64'd0);
        resetn = 1'b1;
        tick();

        run_op(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33, 0);
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33, 0);
        run_op(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 33, 0);
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 33, 0);
        run_op(1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, ZLAT, 0);
        run_op(1'b1, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, ZLAT, 0);

        // Hold in DONE, then a back-to-back signed divide right after the advance.
        run_op(1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 33, 5);
        run_op(1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 33, 0);

        // Flush mid-iteration, then restart two cycles later.
        bus.div_signed = 1'b0;
        bus.src_a      = 32'd100;
        bus.src_b      = 32'd7;
        bus.div_start  = 1'b1;
        repeat (10) tick();
        bus.flush = 1'b1;
        tick();
        bus.flush     = 1'b0;
        bus.div_start = 1'b0;
        chk("flush_valid", 64'(bus.res_valid), 64'd0);
        tick();
        run_op(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33, 0);

        // Squashed instruction: start drops mid-iteration.
        bus.src_a     = 32'd50;
        bus.src_b     = 32'd5;
        bus.div_start = 1'b1;
        repeat (5) tick();
        bus.div_start = 1'b0;
        repeat (40) tick();
        chk("squash_valid", 64'(bus.res_valid), 64'd0);

        // Asynchronous reset in the middle of an operation.
        run_op(1'b0, 32'd77, 32'd4, 32'd19, 32'd1, 33, 0);
        bus.src_a     = 32'd100;
        bus.src_b     = 32'd7;
        bus.div_start = 1'b1;
        repeat (20) tick();
        #2;
        resetn        = 1'b0;
        bus.div_start = 1'b0;
        #1;
        chk("areset_valid", 64'(bus.res_valid), 64'd0);
        chk("areset_quotient", 64'(bus.quotient), 64'd0);
        chk("areset_remainder", 64'(bus.remainder), 64'd0);
        chk("areset_busy", 64'(bus.div_busy), 64'd0);
        tick();
        resetn = 1'b1;
        tick();
        run_op(1'b0, 32'd1, 32'd1, 32'd1, 32'd0, 33, 0);

        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
